hu_audiodec_dma_seq: RTL and testbench

Chunked DMA copy sequencer for the audio-decoder accelerator tile. On a rising edge of `conf_done` it moves `conf_info_num_words` 64-bit words from the source offset to the destination offset. Each chunk is one read burst into an internal buffer, then one write burst out of it. It drives the ESP DMA read/write control and channel interfaces directly and pulses `acc_done` when the job finishes. It replaces the idle DMA stub and becomes the sequencing shell around later decode datapaths.

---
 rtl/hu_audiodec_dma_seq.sv | 152 +++++++++++++++
 tb/tb_hu_audiodec_dma_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hu_audiodec_dma_seq.sv
// Chunked DMA copy sequencer: a rising edge of conf_done copies num_words 64-bit words
// from src to dst through a CHUNK_WORDS-deep buffer, one read burst then one write burst per chunk.
module hu_audiodec_dma_seq #(
    parameter int CHUNK_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] conf_info_src_offset,
    input  logic [31:0] conf_info_dst_offset,
    input  logic [31:0] conf_info_num_words,
    input  logic        conf_done,
    output logic        dma_read_ctrl_valid,
    input  logic        dma_read_ctrl_ready,
    output logic [31:0] dma_read_ctrl_data_index,
    output logic [31:0] dma_read_ctrl_data_length,
    output logic [2:0]  dma_read_ctrl_data_size,
    input  logic        dma_read_chnl_valid,
    output logic        dma_read_chnl_ready,
    input  logic [63:0] dma_read_chnl_data,
    output logic        dma_write_ctrl_valid,
    input  logic        dma_write_ctrl_ready,
    output logic [31:0] dma_write_ctrl_data_index,
    output logic [31:0] dma_write_ctrl_data_length,
    output logic [2:0]  dma_write_ctrl_data_size,
    output logic        dma_write_chnl_valid,
    input  logic        dma_write_chnl_ready,
    output logic [63:0] dma_write_chnl_data,
    output logic        acc_done,
    output logic [31:0] debug
);
    localparam int CW = $clog2(CHUNK_WORDS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // once valid is raised, valid and its payload hold until that edge.
    state_t          state, state_next;
    logic            conf_q1, conf_q2;
    logic [31:0]     src, dst, num, words_done, len;
    logic [CW-1:0]   beat_cnt;
    logic [63:0]     buffer [CHUNK_WORDS];
    logic            conf_rise, rd_beat, wr_beat, last_beat;
    logic [31:0]     remaining, len_calc, words_next;

    assign conf_rise  = conf_q1 & ~conf_q2;
    assign remaining  = num - words_done;
    assign len_calc   = (remaining < 32'(CHUNK_WORDS)) ? remaining : 32'(CHUNK_WORDS);
    assign last_beat  = (32'(beat_cnt) == len - 32'd1);
    assign words_next = words_done + len;
    assign rd_beat    = dma_read_chnl_valid & dma_read_chnl_ready;
    assign wr_beat    = dma_write_chnl_valid & dma_write_chnl_ready;

    assign dma_read_chnl_ready      = (state == RD_DATA);
    assign dma_read_ctrl_data_size  = 3'b011;
    assign dma_write_ctrl_data_size = 3'b011;
    assign debug                    = {state, words_done[28:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (conf_rise) state_next = (conf_info_num_words == 32'd0) ? DONE : RD_REQ;
            RD_REQ:  if (dma_read_ctrl_valid && dma_read_ctrl_ready) state_next = RD_DATA;
            RD_DATA: if (rd_beat && last_beat) state_next = WR_REQ;
            WR_REQ:  if (dma_write_ctrl_valid && dma_write_ctrl_ready) state_next = WR_DATA;
            WR_DATA: if (wr_beat && last_beat) state_next = (words_next == num) ? DONE : RD_REQ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rd_beat) buffer[beat_cnt] <= dma_read_chnl_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conf_q1                    <= 1'b0;
            conf_q2                    <= 1'b0;
            src                        <= '0;
            dst                        <= '0;
            num                        <= '0;
            words_done                 <= '0;
            len                        <= '0;
            beat_cnt                   <= '0;
            acc_done                   <= 1'b0;
            dma_read_ctrl_valid        <= 1'b0;
            dma_read_ctrl_data_index   <= '0;
            dma_read_ctrl_data_length  <= '0;
            dma_write_ctrl_valid       <= 1'b0;
            dma_write_ctrl_data_index  <= '0;
            dma_write_ctrl_data_length <= '0;
            dma_write_chnl_valid       <= 1'b0;
            dma_write_chnl_data        <= '0;
        end else begin
            conf_q1  <= conf_done;
            conf_q2  <= conf_q1;
            acc_done <= (state == DONE);
            case (state)
                IDLE: if (conf_rise) begin
                    src        <= conf_info_src_offset;
                    dst        <= conf_info_dst_offset;
                    num        <= conf_info_num_words;
                    words_done <= '0;
                end
                // First cycle in RD_REQ fixes the chunk length for both bursts.
                RD_REQ: if (!dma_read_ctrl_valid) begin
                    dma_read_ctrl_valid       <= 1'b1;
                    dma_read_ctrl_data_index  <= src + words_done;
                    dma_read_ctrl_data_length <= len_calc;
                    len                       <= len_calc;
                end else if (dma_read_ctrl_ready) begin
                    dma_read_ctrl_valid <= 1'b0;
                end
                RD_DATA: if (rd_beat) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                WR_REQ: if (!dma_write_ctrl_valid) begin
                    dma_write_ctrl_valid       <= 1'b1;
                    dma_write_ctrl_data_index  <= dst + words_done;
                    dma_write_ctrl_data_length <= len;
                end else if (dma_write_ctrl_ready) begin
                    dma_write_ctrl_valid <= 1'b0;
                    dma_write_chnl_valid <= 1'b1;
                    dma_write_chnl_data  <= buffer[0];
                    beat_cnt             <= '0;
                end
                // beat_cnt points at the beat currently presented on the write channel.
                WR_DATA: if (wr_beat) begin
                    if (last_beat) begin
                        dma_write_chnl_valid <= 1'b0;
                        beat_cnt             <= '0;
                        words_done           <= words_next;
                    end else begin
                        beat_cnt            <= beat_cnt + 1'b1;
                        dma_write_chnl_data <= buffer[beat_cnt + 1'b1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hu_audiodec_dma_seq.sv
// Directed bench for hu_audiodec_dma_seq: a DMA responder at the negative edge, a scoreboard
// of read beats checked against write beats, and per-job request/latency checks.
module tb_hu_audiodec_dma_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] conf_info_src_offset, conf_info_dst_offset, conf_info_num_words;
    logic        conf_done;
    logic        dma_read_ctrl_valid, dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic        dma_read_chnl_valid, dma_read_chnl_ready;
    logic [63:0] dma_read_chnl_data;
    logic        dma_write_ctrl_valid, dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index, dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;
    logic        dma_write_chnl_valid, dma_write_chnl_ready;
    logic [63:0] dma_write_chnl_data;
    logic        acc_done;
    logic [31:0] debug;

    hu_audiodec_dma_seq #(.CHUNK_WORDS(16)) dut (
        .clk(clk), .rst(rst),
        .conf_info_src_offset(conf_info_src_offset),
        .conf_info_dst_offset(conf_info_dst_offset),
        .conf_info_num_words(conf_info_num_words),
        .conf_done(conf_done),
        .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
        .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
        .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
        .dma_read_chnl_data(dma_read_chnl_data),
        .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
        .dma_write_ctrl_data_index(dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
        .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
        .dma_write_chnl_data(dma_write_chnl_data),
        .acc_done(acc_done), .debug(debug)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // scoreboard and counters
    logic [63:0] exp_q[$];
    logic [31:0] rd_idx_q[$], rd_len_q[$], wr_idx_q[$], wr_len_q[$];
    int errors = 0, checks = 0;
    bit bp = 0;
    logic [63:0] rd_base = 64'hA0;
    int rd_seq = 0, rd_left = 0, wr_beats = 0, done_cnt = 0;
    int acc_edge = -1, first_rdv = -1, last_wr_edge = -1;
    bit any_valid = 0;
    bit rd_stall = 0, wr_stall = 0, wd_stall = 0;
    logic [31:0] rd_idx_s, rd_len_s, wr_idx_s, wr_len_s;
    logic [63:0] wd_s;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // DMA responder and monitor: drives inputs at negedge, then logs the handshakes of the next posedge
    always @(negedge clk) begin
        if (rst) begin
            rd_left = 0;
            dma_read_ctrl_ready  = 1'b0;
            dma_write_ctrl_ready = 1'b0;
            dma_write_chnl_ready = 1'b0;
            dma_read_chnl_valid  = 1'b0;
            dma_read_chnl_data   = '0;
            rd_stall = 0; wr_stall = 0; wd_stall = 0;
        end else begin
            if (rd_stall) begin
                check("rd_ctrl_hold_valid", 64'(dma_read_ctrl_valid), 64'd1);
                check("rd_ctrl_hold_idx", 64'(dma_read_ctrl_data_index), 64'(rd_idx_s));
                check("rd_ctrl_hold_len", 64'(dma_read_ctrl_data_length), 64'(rd_len_s));
            end
            if (wr_stall) begin
                check("wr_ctrl_hold_valid", 64'(dma_write_ctrl_valid), 64'd1);
                check("wr_ctrl_hold_idx", 64'(dma_write_ctrl_data_index), 64'(wr_idx_s));
                check("wr_ctrl_hold_len", 64'(dma_write_ctrl_data_length), 64'(wr_len_s));
            end
            if (wd_stall) begin
                check("wr_chnl_hold_valid", 64'(dma_write_chnl_valid), 64'd1);
                check("wr_chnl_hold_data", dma_write_chnl_data, wd_s);
            end
            dma_read_ctrl_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            dma_write_ctrl_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            dma_write_chnl_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            dma_read_chnl_valid  = (rd_left > 0) && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
            dma_read_chnl_data   = rd_base + 64'(rd_seq);

            rd_stall = dma_read_ctrl_valid && !dma_read_ctrl_ready;
            rd_idx_s = dma_read_ctrl_data_index; rd_len_s = dma_read_ctrl_data_length;
            wr_stall = dma_write_ctrl_valid && !dma_write_ctrl_ready;
            wr_idx_s = dma_write_ctrl_data_index; wr_len_s = dma_write_ctrl_data_length;
            wd_stall = dma_write_chnl_valid && !dma_write_chnl_ready;
            wd_s     = dma_write_chnl_data;

            if (dma_read_ctrl_valid && first_rdv < 0) first_rdv = cyc;
            if (dma_read_ctrl_valid || dma_write_ctrl_valid || dma_write_chnl_valid) any_valid = 1;
            if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
                rd_idx_q.push_back(dma_read_ctrl_data_index);
                rd_len_q.push_back(dma_read_ctrl_data_length);
                check("rd_size", 64'(dma_read_ctrl_data_size), 64'd3);
                rd_left += int'(dma_read_ctrl_data_length);
            end
            if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
                wr_idx_q.push_back(dma_write_ctrl_data_index);
                wr_len_q.push_back(dma_write_ctrl_data_length);
                check("wr_size", 64'(dma_write_ctrl_data_size), 64'd3);
            end
            if (dma_read_chnl_valid && dma_read_chnl_ready) begin
                exp_q.push_back(dma_read_chnl_data);
                rd_seq++;
                rd_left--;
            end
            if (dma_write_chnl_valid && dma_write_chnl_ready) begin
                if (exp_q.size() == 0) check("wr_extra_beat", 64'd1, 64'd0);
                else check("wr_data", dma_write_chnl_data, exp_q.pop_front());
                wr_beats++;
                last_wr_edge = cyc + 1;
            end
            if (acc_done) begin
                done_cnt++;
                if (acc_edge < 0) acc_edge = cyc;
            end
        end
    end

    // driver tasks
    task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n,
                             input bit hold, output int c);
        conf_done = 1'b0;
        repeat (3) @(negedge clk);
        rd_idx_q.delete(); rd_len_q.delete(); wr_idx_q.delete(); wr_len_q.delete();
        exp_q.delete();
        wr_beats = 0; done_cnt = 0; acc_edge = -1; first_rdv = -1; last_wr_edge = -1; any_valid = 0;
        conf_info_src_offset = s;
        conf_info_dst_offset = d;
        conf_info_num_words  = n;
        conf_done = 1'b1;
        c = cyc;
        @(negedge clk);
        if (!hold) conf_done = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int c;
        int n;
        rst = 1'b1;
        conf_done = 1'b0;
        conf_info_src_offset = '0; conf_info_dst_offset = '0; conf_info_num_words = '0;
        dma_read_ctrl_ready = 1'b0; dma_write_ctrl_ready = 1'b0; dma_write_chnl_ready = 1'b0;
        dma_read_chnl_valid = 1'b0; dma_read_chnl_data = '0;
        repeat (3) @(negedge clk);
        check("rst_rd_ctrl_valid", 64'(dma_read_ctrl_valid), 64'd0);
        check("rst_rd_chnl_ready", 64'(dma_read_chnl_ready), 64'd0);
        check("rst_wr_valids", 64'({dma_write_ctrl_valid, dma_write_chnl_valid}), 64'd0);
        check("rst_acc_done", 64'(acc_done), 64'd0);
        check("rst_debug", 64'(debug), 64'd0);
        check("rst_wr_data", dma_write_chnl_data, 64'd0);
        rst = 1'b0;

        // single chunk
        bp = 0; rd_base = 64'hA0; rd_seq = 0;
        start_job(32'h100, 32'h200, 32'd5, 1'b0, c);
        wait_done("single", 500);
        check("single_first_rd_valid_edge", 64'(first_rdv), 64'(c + 3));
        check("single_rd_count", 64'(rd_idx_q.size()), 64'd1);
        check("single_rd_idx", 64'(rd_idx_q[0]), 64'h100);
        check("single_rd_len", 64'(rd_len_q[0]), 64'd5);
        check("single_wr_count", 64'(wr_idx_q.size()), 64'd1);
        check("single_wr_idx", 64'(wr_idx_q[0]), 64'h200);
        check("single_wr_len", 64'(wr_len_q[0]), 64'd5);
        check("single_wr_beats", 64'(wr_beats), 64'd5);
        check("single_exp_left", 64'(exp_q.size()), 64'd0);
        check("single_done_cnt", 64'(done_cnt), 64'd1);
        check("single_done_latency", 64'(acc_edge), 64'(last_wr_edge + 1));

        // multi-chunk with remainder
        rd_base = 64'h5555_0000_0000_1000; rd_seq = 0;
        start_job(32'h400, 32'h800, 32'd37, 1'b0, c);
        wait_done("multi", 2000);
        check("multi_rd_count", 64'(rd_idx_q.size()), 64'd3);
        check("multi_rd_idx0", 64'(rd_idx_q[0]), 64'h400);
        check("multi_rd_idx1", 64'(rd_idx_q[1]), 64'h410);
        check("multi_rd_idx2", 64'(rd_idx_q[2]), 64'h420);
        check("multi_rd_len0", 64'(rd_len_q[0]), 64'd16);
        check("multi_rd_len1", 64'(rd_len_q[1]), 64'd16);
        check("multi_rd_len2", 64'(rd_len_q[2]), 64'd5);
        check("multi_wr_idx0", 64'(wr_idx_q[0]), 64'h800);
        check("multi_wr_idx1", 64'(wr_idx_q[1]), 64'h810);
        check("multi_wr_idx2", 64'(wr_idx_q[2]), 64'h820);
        check("multi_wr_len2", 64'(wr_len_q[2]), 64'd5);
        check("multi_wr_beats", 64'(wr_beats), 64'd37);
        check("multi_debug", 64'(debug), 64'd37);
        check("multi_done_cnt", 64'(done_cnt), 64'd1);

        // zero length
        start_job(32'h10, 32'h20, 32'd0, 1'b0, c);
        wait_done("zero", 100);
        check("zero_done_edge", 64'(acc_edge), 64'(c + 3));
        check("zero_no_valid", 64'(any_valid), 64'd0);
        check("zero_done_cnt", 64'(done_cnt), 64'd1);

        // backpressure with index wrap
        bp = 1; rd_base = 64'hBEEF_0000_0000_0000; rd_seq = 0;
        start_job(32'hFFFF_FFF8, 32'h40, 32'd20, 1'b0, c);
        wait_done("bp", 5000);
        bp = 0;
        check("bp_rd_count", 64'(rd_idx_q.size()), 64'd2);
        check("bp_rd_idx0", 64'(rd_idx_q[0]), 64'hFFFF_FFF8);
        check("bp_rd_idx1_wrap", 64'(rd_idx_q[1]), 64'h0000_0008);
        check("bp_rd_len1", 64'(rd_len_q[1]), 64'd4);
        check("bp_wr_idx1", 64'(wr_idx_q[1]), 64'h50);
        check("bp_wr_beats", 64'(wr_beats), 64'd20);
        check("bp_exp_left", 64'(exp_q.size()), 64'd0);
        check("bp_done_cnt", 64'(done_cnt), 64'd1);

        // reset mid-RD_DATA, then restart
        rd_base = 64'h7700; rd_seq = 0;
        start_job(32'h1000, 32'h2000, 32'd40, 1'b0, c);
        n = 0;
        while (!dma_read_chnl_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reset_reached_rd_data", 64'(dma_read_chnl_ready), 64'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_rd_chnl_ready", 64'(dma_read_chnl_ready), 64'd0);
        check("arst_valids", 64'({dma_read_ctrl_valid, dma_write_ctrl_valid, dma_write_chnl_valid}), 64'd0);
        check("arst_rd_idx", 64'(dma_read_ctrl_data_index), 64'd0);
        check("arst_rd_len", 64'(dma_read_ctrl_data_length), 64'd0);
        check("arst_debug", 64'(debug), 64'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("arst_no_done", 64'(done_cnt), 64'd0);
        start_job(32'h3000, 32'h4000, 32'd3, 1'b0, c);
        wait_done("restart", 500);
        check("restart_rd_idx", 64'(rd_idx_q[0]), 64'h3000);
        check("restart_rd_len", 64'(rd_len_q[0]), 64'd3);
        check("restart_wr_idx", 64'(wr_idx_q[0]), 64'h4000);
        check("restart_wr_beats", 64'(wr_beats), 64'd3);
        check("restart_done_cnt", 64'(done_cnt), 64'd1);

        // held conf_done
        start_job(32'h60, 32'h70, 32'd4, 1'b1, c);
        wait_done("held", 500);
        repeat (20) @(negedge clk);
        check("held_done_cnt", 64'(done_cnt), 64'd1);
        check("held_rd_count", 64'(rd_idx_q.size()), 64'd1);
        check("held_idle", 64'(debug[31:29]), 64'd0);
        start_job(32'h60, 32'h90, 32'd2, 1'b0, c);
        wait_done("held_next", 500);
        check("held_next_done_cnt", 64'(done_cnt), 64'd1);
        check("held_next_wr_idx", 64'(wr_idx_q[0]), 64'h90);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
